// File: rtl/mips_alu_issue_pkg.sv
// mips_alu_issue_pkg
//   Shared definitions for the ALU issue stage and the ALU itself:
//   - alu_op codes from the main decoder
//   - R-type funct codes understood by the ALU
//   - ALU control encodings (alu_ctl_e)
//   - issue-register state encoding
//   - alu_decode(): maps (alu_op, funct) to an ALU control code
package mips_alu_issue_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_ORI   = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_AND     = 4'd0,
      ALU_OR      = 4'd1,
      ALU_ADD     = 4'd2,
      ALU_SUB     = 4'd3,
      ALU_SLT     = 4'd4,
      ALU_NOR     = 4'd5,
      ALU_ILLEGAL = 4'd15
   } alu_ctl_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } issue_state_e;

   // ALU_ILLEGAL is produced only for an unknown funct under ALUOP_FUNCT,
   // so callers may derive the illegal flag from the returned code.
   function automatic alu_ctl_e alu_decode(input logic [1:0] op,
                                           input logic [5:0] funct);
      alu_ctl_e ctl;
      ctl = ALU_ILLEGAL;
      case (op)
         ALUOP_ADD: ctl = ALU_ADD;
         ALUOP_SUB: ctl = ALU_SUB;
         ALUOP_ORI: ctl = ALU_OR;
         default: begin
            case (funct)
               FUNCT_AND: ctl = ALU_AND;
               FUNCT_OR:  ctl = ALU_OR;
               FUNCT_ADD: ctl = ALU_ADD;
               FUNCT_SUB: ctl = ALU_SUB;
               FUNCT_SLT: ctl = ALU_SLT;
               FUNCT_NOR: ctl = ALU_NOR;
               default:   ctl = ALU_ILLEGAL;
            endcase
         end
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/mips_fwd_mux.sv
// mips_fwd_mux
//   Operand forwarding select for one source register. EX/MEM wins over
//   MEM/WB; register 0 is never forwarded.
//   Ports:
//     addr_i        source register number
//     rf_data_i     register-file read data
//     exmem_wr_i/rd_i/data_i   EX/MEM writeback candidate
//     memwb_wr_i/rd_i/data_i   MEM/WB writeback candidate
//     data_o        selected operand
module mips_fwd_mux
   import mips_alu_issue_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic [4:0]     addr_i,
   input  logic [LEN-1:0] rf_data_i,
   input  logic           exmem_wr_i,
   input  logic [4:0]     exmem_rd_i,
   input  logic [LEN-1:0] exmem_data_i,
   input  logic           memwb_wr_i,
   input  logic [4:0]     memwb_rd_i,
   input  logic [LEN-1:0] memwb_data_i,
   output logic [LEN-1:0] data_o
);

   logic nz;
   logic hit_exmem;
   logic hit_memwb;

   assign nz        = (addr_i != 5'd0);
   assign hit_exmem = nz && exmem_wr_i && (exmem_rd_i == addr_i);
   assign hit_memwb = nz && memwb_wr_i && (memwb_rd_i == addr_i);

   always_comb begin
      data_o = rf_data_i;
      if (hit_exmem)      data_o = exmem_data_i;
      else if (hit_memwb) data_o = memwb_data_i;
   end

endmodule

// File: rtl/mips_alu_issue.sv
// mips_alu_issue
//   One-entry issue register between decode and the ALU. Decodes the ALU
//   control code, resolves operand forwarding at accept time and holds the
//   result under valid/ready backpressure.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     in_valid / in_ready           handshake from decode
//     alu_op, funct                 operation selection
//     rs/rt/rd_addr, rs/rt_data     register operands
//     imm, alu_src                  immediate and B-operand select
//     exmem_*, memwb_*              forwarding sources
//     flush                         discard held / incoming entry
//     out_valid / out_ready         handshake to the ALU
//     alu_ctl, alu_a, alu_b, dest, illegal   registered issue outputs
module mips_alu_issue
   import mips_alu_issue_pkg::*;
#(
   parameter int LEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [1:0]     alu_op,
   input  logic [5:0]     funct,
   input  logic [4:0]     rs_addr,
   input  logic [4:0]     rt_addr,
   input  logic [4:0]     rd_addr,
   input  logic [LEN-1:0] rs_data,
   input  logic [LEN-1:0] rt_data,
   input  logic [15:0]    imm,
   input  logic           alu_src,
   input  logic           exmem_wr,
   input  logic [4:0]     exmem_rd,
   input  logic [LEN-1:0] exmem_data,
   input  logic           memwb_wr,
   input  logic [4:0]     memwb_rd,
   input  logic [LEN-1:0] memwb_data,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [3:0]     alu_ctl,
   output logic [LEN-1:0] alu_a,
   output logic [LEN-1:0] alu_b,
   output logic [4:0]     dest,
   output logic           illegal
);

   issue_state_e   state_q, state_d;
   logic           load;
   logic           accept;

   alu_ctl_e       ctl_d, ctl_q;
   logic [LEN-1:0] a_d, a_q;
   logic [LEN-1:0] b_d, b_q;
   logic [LEN-1:0] rt_fwd;
   logic [4:0]     dest_d, dest_q;
   logic           ill_d, ill_q;

   assign in_ready = (state_q == ST_EMPTY) || out_ready;
   assign accept   = in_valid && in_ready;

   mips_fwd_mux #(.LEN(LEN)) u_fwd_rs (
      .addr_i       (rs_addr),
      .rf_data_i    (rs_data),
      .exmem_wr_i   (exmem_wr),
      .exmem_rd_i   (exmem_rd),
      .exmem_data_i (exmem_data),
      .memwb_wr_i   (memwb_wr),
      .memwb_rd_i   (memwb_rd),
      .memwb_data_i (memwb_data),
      .data_o       (a_d)
   );

   mips_fwd_mux #(.LEN(LEN)) u_fwd_rt (
      .addr_i       (rt_addr),
      .rf_data_i    (rt_data),
      .exmem_wr_i   (exmem_wr),
      .exmem_rd_i   (exmem_rd),
      .exmem_data_i (exmem_data),
      .memwb_wr_i   (memwb_wr),
      .memwb_rd_i   (memwb_rd),
      .memwb_data_i (memwb_data),
      .data_o       (rt_fwd)
   );

   // ORI zero-extends its immediate; every other immediate form sign-extends.
   always_comb begin
      ctl_d  = alu_decode(alu_op, funct);
      ill_d  = (ctl_d == ALU_ILLEGAL);
      b_d    = rt_fwd;
      dest_d = rd_addr;
      if (alu_src) begin
         dest_d = rt_addr;
         if (alu_op == ALUOP_ORI) b_d = {{(LEN-16){1'b0}}, imm};
         else                     b_d = {{(LEN-16){imm[15]}}, imm};
      end
   end

   // Flush beats a simultaneous accept: the incoming op is dropped and the
   // data registers are not reloaded.
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else if (accept) begin
         state_d = ST_FULL;
         load    = 1'b1;
      end else if ((state_q == ST_FULL) && out_ready) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   // Payload is captured only on load, so a stalled entry keeps the
   // forwarding values it saw at accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q  <= ALU_AND;
         a_q    <= '0;
         b_q    <= '0;
         dest_q <= '0;
         ill_q  <= 1'b0;
      end else if (load) begin
         ctl_q  <= ctl_d;
         a_q    <= a_d;
         b_q    <= b_d;
         dest_q <= dest_d;
         ill_q  <= ill_d;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign alu_ctl   = ctl_q;
   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign dest      = dest_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_mips_alu_issue.sv
module tb_mips_alu_issue;

   localparam int LEN = 32;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [1:0]     alu_op;
   logic [5:0]     funct;
   logic [4:0]     rs_addr, rt_addr, rd_addr;
   logic [LEN-1:0] rs_data, rt_data;
   logic [15:0]    imm;
   logic           alu_src;
   logic           exmem_wr;
   logic [4:0]     exmem_rd;
   logic [LEN-1:0] exmem_data;
   logic           memwb_wr;
   logic [4:0]     memwb_rd;
   logic [LEN-1:0] memwb_data;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [3:0]     alu_ctl;
   logic [LEN-1:0] alu_a, alu_b;
   logic [4:0]     dest;
   logic           illegal;

   int n_cmp;
   int n_err;

   mips_alu_issue #(.LEN(LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alu_op     (alu_op),
      .funct      (funct),
      .rs_addr    (rs_addr),
      .rt_addr    (rt_addr),
      .rd_addr    (rd_addr),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .imm        (imm),
      .alu_src    (alu_src),
      .exmem_wr   (exmem_wr),
      .exmem_rd   (exmem_rd),
      .exmem_data (exmem_data),
      .memwb_wr   (memwb_wr),
      .memwb_rd   (memwb_rd),
      .memwb_data (memwb_data),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .alu_ctl    (alu_ctl),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .dest       (dest),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected done");
      $fatal(1, "timeout");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      in_valid = 0; alu_op = 2'b00; funct = 6'h00;
      rs_addr = 0; rt_addr = 0; rd_addr = 0; rs_data = 0; rt_data = 0;
      imm = 0; alu_src = 0;
      exmem_wr = 0; exmem_rd = 0; exmem_data = 0;
      memwb_wr = 0; memwb_rd = 0; memwb_data = 0;
      flush = 0; out_ready = 1;
   endtask

   task automatic set_rtype(input logic [5:0] f, input logic [4:0] rs, input logic [31:0] rsd,
                            input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd);
      in_valid = 1; alu_op = 2'b10; funct = f; alu_src = 0;
      rs_addr = rs; rs_data = rsd; rt_addr = rt; rt_data = rtd; rd_addr = rd;
   endtask

   task automatic check_zero(input string pfx);
      check_eq({pfx, ".out_valid"}, {31'b0, out_valid}, 32'd0);
      check_eq({pfx, ".alu_ctl"},   {28'b0, alu_ctl},   32'd0);
      check_eq({pfx, ".alu_a"},     alu_a,              32'd0);
      check_eq({pfx, ".alu_b"},     alu_b,              32'd0);
      check_eq({pfx, ".dest"},      {27'b0, dest},      32'd0);
      check_eq({pfx, ".illegal"},   {31'b0, illegal},   32'd0);
   endtask

   // funct decode table: funct -> expected alu_ctl
   logic [5:0] ft_f [4] = '{6'h25, 6'h22, 6'h2A, 6'h27};
   logic [3:0] ft_c [4] = '{4'd1, 4'd3, 4'd4, 4'd5};

   initial begin
      n_cmp = 0;
      n_err = 0;
      clear_inputs();
      rst_n = 1;
      #1 rst_n = 0;
      #1 check_zero("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      // R-type ADD, no forwarding
      set_rtype(6'h20, 5'd1, 32'd5, 5'd2, 32'd7, 5'd4);
      @(negedge clk);
      check_eq("add.out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("add.alu_ctl", {28'b0, alu_ctl}, 32'd2);
      check_eq("add.alu_a", alu_a, 32'd5);
      check_eq("add.alu_b", alu_b, 32'd7);
      check_eq("add.dest", {27'b0, dest}, 32'd4);
      check_eq("add.illegal", {31'b0, illegal}, 32'd0);

      // forward priority: EX/MEM beats MEM/WB
      set_rtype(6'h22, 5'd3, 32'h11, 5'd5, 32'h22, 5'd6);
      exmem_wr = 1; exmem_rd = 3; exmem_data = 32'hAA;
      memwb_wr = 1; memwb_rd = 3; memwb_data = 32'hBB;
      @(negedge clk);
      check_eq("fwd_pri.alu_a", alu_a, 32'hAA);
      check_eq("fwd_pri.alu_b", alu_b, 32'h22);
      check_eq("fwd_pri.alu_ctl", {28'b0, alu_ctl}, 32'd3);

      // rt forwarded from MEM/WB when EX/MEM targets another register
      set_rtype(6'h24, 5'd7, 32'h70, 5'd3, 32'h30, 5'd8);
      exmem_rd = 9;
      @(negedge clk);
      check_eq("fwd_wb.alu_a", alu_a, 32'h70);
      check_eq("fwd_wb.alu_b", alu_b, 32'hBB);
      check_eq("fwd_wb.alu_ctl", {28'b0, alu_ctl}, 32'd0);

      // register 0 is never forwarded
      set_rtype(6'h20, 5'd0, 32'h1234, 5'd0, 32'h5678, 5'd1);
      exmem_rd = 0; memwb_rd = 0;
      @(negedge clk);
      check_eq("r0.alu_a", alu_a, 32'h1234);
      check_eq("r0.alu_b", alu_b, 32'h5678);
      exmem_wr = 0; memwb_wr = 0;

      // remaining funct codes, streaming one per cycle
      for (int i = 0; i < 4; i++) begin
         set_rtype(ft_f[i], 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
         @(negedge clk);
         check_eq($sformatf("funct_%02h.alu_ctl", ft_f[i]), {28'b0, alu_ctl}, {28'b0, ft_c[i]});
         check_eq($sformatf("funct_%02h.out_valid", ft_f[i]), {31'b0, out_valid}, 32'd1);
      end

      // immediate paths
      in_valid = 1; alu_op = 2'b00; alu_src = 1; imm = 16'hFFFF;
      rs_addr = 1; rs_data = 32'd9; rt_addr = 5'd8; rd_addr = 5'd12;
      @(negedge clk);
      check_eq("imm_sx.alu_b", alu_b, 32'hFFFF_FFFF);
      check_eq("imm_sx.alu_ctl", {28'b0, alu_ctl}, 32'd2);
      check_eq("imm_sx.dest", {27'b0, dest}, 32'd8);
      alu_op = 2'b11;
      @(negedge clk);
      check_eq("imm_zx.alu_b", alu_b, 32'h0000_FFFF);
      check_eq("imm_zx.alu_ctl", {28'b0, alu_ctl}, 32'd1);

      // backpressure: entry (ORI result) held for 3 cycles, then drain+refill
      out_ready = 0;
      set_rtype(6'h24, 5'd4, 32'h0F0F, 5'd2, 32'h00FF, 5'd5);
      exmem_wr = 1; exmem_rd = 1; exmem_data = 32'hDEAD;
      #1 check_eq("stall.in_ready", {31'b0, in_ready}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("stall.in_ready", {31'b0, in_ready}, 32'd0);
         check_eq("stall.out_valid", {31'b0, out_valid}, 32'd1);
         check_eq("stall.alu_b", alu_b, 32'h0000_FFFF);
         check_eq("stall.alu_a", alu_a, 32'd9);
         check_eq("stall.alu_ctl", {28'b0, alu_ctl}, 32'd1);
      end
      out_ready = 1;
      #1 check_eq("drain.in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      check_eq("refill.out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("refill.alu_ctl", {28'b0, alu_ctl}, 32'd0);
      check_eq("refill.alu_a", alu_a, 32'h0F0F);
      check_eq("refill.alu_b", alu_b, 32'h00FF);
      exmem_wr = 0;

      // drain without accept: out_valid drops, payload holds
      in_valid = 0;
      @(negedge clk);
      check_eq("drain.out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("drain.alu_a", alu_a, 32'h0F0F);

      // flush with simultaneous accept
      set_rtype(6'h20, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3);
      flush = 1;
      @(negedge clk);
      check_eq("flush.out_valid", {31'b0, out_valid}, 32'd0);
      flush = 0;

      // illegal funct, then held, then async reset mid-hold
      set_rtype(6'h3F, 5'd1, 32'h55, 5'd2, 32'h66, 5'd7);
      @(negedge clk);
      check_eq("illegal.alu_ctl", {28'b0, alu_ctl}, 32'd15);
      check_eq("illegal.illegal", {31'b0, illegal}, 32'd1);
      check_eq("illegal.out_valid", {31'b0, out_valid}, 32'd1);
      in_valid = 0; out_ready = 0;
      @(negedge clk);
      #1 rst_n = 0;
      #1 check_zero("async_rst");
      @(negedge clk);
      rst_n = 1;

      // first accept on first edge after reset release
      set_rtype(6'h25, 5'd1, 32'h3, 5'd2, 32'h4, 5'd9);
      out_ready = 1;
      @(negedge clk);
      check_eq("post_rst.out_valid", {31'b0, out_valid}, 32'd1);
      check_eq("post_rst.alu_ctl", {28'b0, alu_ctl}, 32'd1);
      check_eq("post_rst.dest", {27'b0, dest}, 32'd9);
      in_valid = 0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
